// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: bundles the job-control, operand-stream and result
// signals of the MAC sequencer.
//   cfg_len/start          job request and kernel length
//   in_valid/in_ready      operand stream handshake, in_x/in_w signed 8-bit
//   out_valid/out_ready    result handshake, out_acc/out_ovf result payload
//   busy/done/err          status
// master = job source / operand fetch side, slave = the sequencer.
interface mac_seq_ctrl_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  logic [LEN_W-1:0]        cfg_len;
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [7:0]       in_x;
  logic signed [7:0]       in_w;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_ovf;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output cfg_len, start, in_valid, in_x, in_w, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy, done, err
  );

  modport slave (
    input  cfg_len, start, in_valid, in_x, in_w, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy, done, err
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: streams signed 8-bit activation/weight pairs through one
// shared 8x8 multiplier and accumulates the products, returning one result
// per programmed kernel length.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mac_seq_ctrl_if.slave (job control, operand stream, result, status)
//
// state | meaning
// IDLE  | waiting for start; out_acc holds the previous result
// RUN   | accepting operand pairs until rem reaches zero
// DRAIN | no input accepted; waiting for the pipeline to empty into acc
// OUT   | result presented, held until out_ready

module multiply_8x8 (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

module mac_seq_ctrl #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        rem;

  logic                    va;
  logic                    vb;
  logic signed [7:0]       xa;
  logic signed [7:0]       wa;
  logic signed [15:0]      prod;
  logic signed [15:0]      pb;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    sum_ovf;

  logic                    in_xfer;
  logic                    start_ok;

  assign bus.in_ready = (state == RUN);
  assign bus.busy     = (state != IDLE);

  assign in_xfer  = bus.in_valid && (state == RUN);
  assign start_ok = (state == IDLE) && bus.start && (bus.cfg_len != '0);

  multiply_8x8 u_mul (
    .a (xa),
    .b (wa),
    .p (prod)
  );

  assign prod_ext = ACC_W'(pb);
  assign sum      = acc + prod_ext;
  // Signed overflow: addends agree in sign but the wrapped sum does not.
  assign sum_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc[ACC_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rem           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_acc   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.cfg_len != '0) begin
              rem   <= bus.cfg_len;
              state <= RUN;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_xfer) begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Both valid bits low means the last product was added on the
          // previous edge, so acc is final here.
          if (!va && !vb) begin
            state         <= OUT;
            bus.out_valid <= 1'b1;
            bus.out_acc   <= acc;
            bus.out_ovf   <= ovf;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va  <= 1'b0;
      vb  <= 1'b0;
      xa  <= '0;
      wa  <= '0;
      pb  <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      va <= in_xfer;
      if (in_xfer) begin
        xa <= bus.in_x;
        wa <= bus.in_w;
      end
      vb <= va;
      if (va) pb <= prod;
      // vb is always low in IDLE, so the clear never races an add.
      if (start_ok) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (vb) begin
        acc <= sum;
        if (sum_ovf) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.ACC_W(24), .LEN_W(8)) b24 ();
  mac_seq_ctrl_if #(.ACC_W(16), .LEN_W(8)) b16 ();

  mac_seq_ctrl #(.ACC_W(24), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b24.slave)
  );

  mac_seq_ctrl #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16.slave)
  );

  int total = 0;
  int bad = 0;
  int px[$];
  int pw[$];

  typedef struct packed {
    bit             s16;
    int             len;
    int             gap;
    int             hold;
    logic [3:0][7:0] xs;
    logic [3:0][7:0] ws;
    longint         exp_acc;
    bit             exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][7:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic bit f_ready(input bit s16);  return s16 ? b16.in_ready  : b24.in_ready;  endfunction
  function automatic bit f_ovalid(input bit s16); return s16 ? b16.out_valid : b24.out_valid; endfunction
  function automatic bit f_ovf(input bit s16);    return s16 ? b16.out_ovf   : b24.out_ovf;   endfunction
  function automatic bit f_busy(input bit s16);   return s16 ? b16.busy      : b24.busy;      endfunction
  function automatic bit f_done(input bit s16);   return s16 ? b16.done      : b24.done;      endfunction
  function automatic bit f_err(input bit s16);    return s16 ? b16.err       : b24.err;       endfunction
  function automatic longint f_acc(input bit s16);
    return s16 ? longint'(b16.out_acc) : longint'(b24.out_acc);
  endfunction

  task automatic drv_start(input bit s16, input int len, input bit st);
    if (s16) begin b16.cfg_len = 8'(len); b16.start = st; end
    else     begin b24.cfg_len = 8'(len); b24.start = st; end
  endtask

  task automatic drv_in(input bit s16, input bit v, input int x, input int w);
    if (s16) begin b16.in_valid = v; b16.in_x = 8'(x); b16.in_w = 8'(w); end
    else     begin b24.in_valid = v; b24.in_x = 8'(x); b24.in_w = 8'(w); end
  endtask

  task automatic drv_ordy(input bit s16, input bit r);
    if (s16) b16.out_ready = r; else b24.out_ready = r;
  endtask

  // Reference: exact integer sum of products, wrapped to the result width
  // after each add; overflow whenever an exact partial sum leaves the range.
  function automatic void model(input bit s16, input int len, output longint acc, output bit ovf);
    longint m, hi, lo, ex, r;
    m   = longint'(1) << (s16 ? 16 : 24);
    hi  = m / 2 - 1;
    lo  = -(m / 2);
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < len; i++) begin
      ex = acc + longint'(px[i] * pw[i]);
      if (ex > hi || ex < lo) ovf = 1'b1;
      r = ex % m;
      if (r < 0) r += m;
      if (r > hi) r -= m;
      acc = r;
    end
  endfunction

  task automatic run_job(input bit s16, input int len, input int gap, input int hold,
                         output longint acc, output bit ovf);
    int lat;
    bit r;
    bit ok;
    longint acc0;
    drv_start(s16, len, 1'b1);
    tick;
    drv_start(s16, int'($urandom_range(0, 255)), 1'b0);
    check("busy_after_start", f_busy(s16), 1);
    check("done_low_in_run", f_done(s16), 0);
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          drv_in(s16, 1'b0, 0, 0);
          tick;
        end
      end
      drv_in(s16, 1'b1, px[i], pw[i]);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        r = f_ready(s16);
        tick;
        ok = r;
      end
      if (!ok) check("in_xfer_timeout", 0, 1);
    end
    drv_in(s16, 1'b0, 0, 0);
    check("ready_low_after_last", f_ready(s16), 0);
    lat = 0;
    for (int k = 0; k < 20 && !f_ovalid(s16); k++) begin
      tick;
      lat++;
    end
    check("out_latency", lat, 3);
    acc0 = f_acc(s16);
    for (int h = 0; h < hold; h++) begin
      drv_start(s16, 0, (h == 3));
      tick;
      check("hold_valid", f_ovalid(s16), 1);
      check("hold_acc", f_acc(s16), acc0);
      check("hold_ready", f_ready(s16), 0);
      check("hold_err", f_err(s16), 0);
      check("hold_done", f_done(s16), 0);
    end
    drv_start(s16, 0, 1'b0);
    acc = f_acc(s16);
    ovf = f_ovf(s16);
    drv_ordy(s16, 1'b1);
    tick;
    drv_ordy(s16, 1'b0);
    check("done_pulse", f_done(s16), 1);
    check("valid_drop", f_ovalid(s16), 0);
    check("busy_drop", f_busy(s16), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc, macc;
    bit ovf, movf;
    vec_t v;

    drv_start(1'b0, 0, 1'b0); drv_start(1'b1, 0, 1'b0);
    drv_in(1'b0, 1'b0, 0, 0); drv_in(1'b1, 1'b0, 0, 0);
    drv_ordy(1'b0, 1'b0); drv_ordy(1'b1, 1'b0);
    rst_n = 1'b0;
    tick; tick;
    check("rst_busy", f_busy(0), 0);
    check("rst_ready", f_ready(0), 0);
    check("rst_valid", f_ovalid(0), 0);
    check("rst_acc", f_acc(0), 0);
    check("rst_ovf", f_ovf(0), 0);
    check("rst_done", f_done(0), 0);
    check("rst_err", f_err(0), 0);
    rst_n = 1'b1;
    tick;

    //            s16  len gap hold xs                     ws                     acc     ovf
    vecs[0] = '{1'b0, 3, 0, 0,  pk(3, -2, -128, 0),    pk(4, 5, -128, 0),     16386,  1'b0};
    vecs[1] = '{1'b0, 4, 2, 0,  pk(1, 127, -1, 0),     pk(1, 127, 127, -128), 16003,  1'b0};
    vecs[2] = '{1'b0, 3, 0, 10, pk(5, 7, -9, 0),       pk(6, -8, 10, 0),      -116,   1'b0};
    vecs[3] = '{1'b1, 2, 0, 0,  pk(-128, -128, 0, 0),  pk(-128, -128, 0, 0),  -32768, 1'b1};
    vecs[4] = '{1'b1, 1, 1, 0,  pk(2, 0, 0, 0),        pk(3, 0, 0, 0),        6,      1'b0};

    for (int t = 0; t < 5; t++) begin
      v = vecs[t];
      px.delete(); pw.delete();
      for (int j = 0; j < v.len; j++) begin
        px.push_back(int'($signed(v.xs[j])));
        pw.push_back(int'($signed(v.ws[j])));
      end
      run_job(v.s16, v.len, v.gap, v.hold, acc, ovf);
      check("vec_acc", acc, v.exp_acc);
      check("vec_ovf", longint'(ovf), longint'(v.exp_ovf));
      model(v.s16, v.len, macc, movf);
      check("vec_model_acc", acc, macc);
    end

    drv_start(1'b0, 0, 1'b1);
    tick;
    drv_start(1'b0, 0, 1'b0);
    check("err_pulse", f_err(0), 1);
    check("err_busy", f_busy(0), 0);
    tick;
    check("err_clear", f_err(0), 0);

    px.delete(); pw.delete();
    for (int j = 0; j < 255; j++) begin px.push_back(-128); pw.push_back(-128); end
    run_job(1'b0, 255, 0, 0, acc, ovf);
    check("len255_acc", acc, 4177920);
    check("len255_ovf", longint'(ovf), 0);

    for (int n = 0; n < 20; n++) begin
      bit s16;
      int len;
      s16 = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      px.delete(); pw.delete();
      for (int j = 0; j < len; j++) begin
        px.push_back(int'($urandom_range(0, 255)) - 128);
        pw.push_back(int'($urandom_range(0, 255)) - 128);
      end
      run_job(s16, len, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), acc, ovf);
      model(s16, len, macc, movf);
      check("rand_acc", acc, macc);
      check("rand_ovf", longint'(ovf), longint'(movf));
    end

    // Abort a 5-pair job after two transfers.
    drv_start(1'b0, 5, 1'b1);
    tick;
    drv_start(1'b0, 5, 1'b0);
    drv_in(1'b0, 1'b1, 100, 100);
    tick; tick;
    rst_n = 1'b0;
    #1;
    check("abort_busy", f_busy(0), 0);
    check("abort_ready", f_ready(0), 0);
    check("abort_valid", f_ovalid(0), 0);
    check("abort_acc", f_acc(0), 0);
    check("abort_ovf", f_ovf(0), 0);
    check("abort_done", f_done(0), 0);
    drv_in(1'b0, 1'b0, 0, 0);
    tick;
    rst_n = 1'b1;
    tick;
    px.delete(); pw.delete();
    px.push_back(5); pw.push_back(-5);
    run_job(1'b0, 1, 0, 0, acc, ovf);
    check("post_abort_acc", acc, -25);
    check("post_abort_ovf", longint'(ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
